// File: rtl/data_memory_banked.sv
// data_memory_banked: word-organised data memory with byte enables and a multi-cycle stall handshake
module data_memory_banked #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    busywait
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q, merged;
  logic [BYTES-1:0]        be_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    accept, commit;
  assign readdata = rdata_q;
  // request acceptance, stall output and next-state selection
  always_comb begin
    accept   = state_q == IDLE && (read ^ write);
    commit   = state_q == ACCESS && cnt_q == 8'(LATENCY - 1);
    busywait = !reset && (accept || state_q == ACCESS);
    state_d  = accept ? ACCESS : commit ? DONE : state_q == DONE ? IDLE : state_q;
    cnt_d    = accept ? 8'd0 : state_q == ACCESS ? cnt_q + 8'd1 : cnt_q;
  end
  // overlay enabled lanes of the captured write data onto the stored word
  always_comb begin
    merged = mem_q[addr_q];
    for (int k = 0; k < BYTES; k++)
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
  end
  // state, counter and request capture; captured values hold for the whole transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= write;
        addr_q  <= address;
        wdata_q <= writedata;
        be_q    <= byteenable;
      end
    end
  end
  // array and read register update only on the final ACCESS edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else if (commit) begin
      if (wr_q) mem_q[addr_q] <= merged;
      else rdata_q <= mem_q[addr_q];
    end
  end
endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked: directed checks of the banked data memory handshake, byte merging and reset
module tb_data_memory_banked;
  logic clk = 1'b0;
  logic rst;
  logic rd0, wr0, bw0, rd1, wr1, bw1;
  logic [5:0] ad0, ad1;
  logic [31:0] wd0, rdat0;
  logic [63:0] wd1, rdat1;
  logic [3:0] be0;
  logic [7:0] be1;
  int vec = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  data_memory_banked #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(4)) u0 (
    .clock(clk), .reset(rst), .read(rd0), .write(wr0), .address(ad0),
    .writedata(wd0), .byteenable(be0), .readdata(rdat0), .busywait(bw0));

  data_memory_banked #(.ADDR_WIDTH(6), .DATA_WIDTH(64), .LATENCY(1)) u1 (
    .clock(clk), .reset(rst), .read(rd1), .write(wr1), .address(ad1),
    .writedata(wd1), .byteenable(be1), .readdata(rdat1), .busywait(bw1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one transaction: counts stalled cycles, then checks readdata in the DONE cycle
  task automatic tx(input bit s, input bit w, input logic [5:0] a, input logic [63:0] d,
                    input logic [7:0] be, input bit pert, input int exp_n,
                    input logic [63:0] exp_rd, input string tag);
    int n = 0;
    @(negedge clk);
    if (s) begin rd1 = !w; wr1 = w; ad1 = a; wd1 = d; be1 = be; end
    else begin rd0 = !w; wr0 = w; ad0 = a; wd0 = d[31:0]; be0 = be[3:0]; end
    #1;
    while ((s ? bw1 : bw0) && n < 300) begin
      n++;
      if (pert && n == 2) begin ad0 = 6'd6; wd0 = '1; be0 = '1; end
      @(negedge clk);
      #1;
    end
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
    chk({tag, "_readdata"}, s ? rdat1 : {32'b0, rdat0}, exp_rd);
  endtask

  initial begin
    rst = 1; rd0 = 1; wr0 = 0; ad0 = 0; wd0 = 0; be0 = 0;
    rd1 = 0; wr1 = 0; ad1 = 0; wd1 = 0; be1 = 0;
    #2;
    chk("reset_busy", 64'(bw0), 64'd0);
    chk("reset_rdata", {32'b0, rdat0}, 64'd0);
    rd0 = 0;
    @(negedge clk);
    rst = 0;
    tx(0, 0, 6'h3F, 0, 0, 0, 5, 64'h0, "rd_3f");
    @(negedge clk); #1;
    chk("idle_after_done", 64'(bw0), 64'd0);
    tx(0, 1, 6'd5, 64'hDEADBEEF, 8'hF, 0, 5, 64'h0, "wr5_full");
    tx(0, 0, 6'd5, 0, 0, 0, 5, 64'hDEADBEEF, "rd5_full");
    tx(0, 1, 6'd5, 64'h000000AA, 8'h1, 0, 5, 64'hDEADBEEF, "wr5_lane0");
    tx(0, 1, 6'd5, 64'h12340000, 8'hC, 0, 5, 64'hDEADBEEF, "wr5_upper");
    tx(0, 0, 6'd5, 0, 0, 0, 5, 64'h1234BEAA, "rd5_merge");
    tx(0, 1, 6'd5, 64'hFFFFFFFF, 8'h0, 0, 5, 64'h1234BEAA, "wr5_be0");
    tx(0, 1, 6'd6, 64'h55555555, 8'hF, 0, 5, 64'h1234BEAA, "wr6");
    tx(0, 0, 6'd5, 0, 0, 1, 5, 64'h1234BEAA, "rd5_perturb");
    @(negedge clk);
    rd0 = 1; wr0 = 1; ad0 = 6'd5; wd0 = 0; be0 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rdwr_busy", 64'(bw0), 64'd0);
      @(negedge clk);
    end
    rd0 = 0; wr0 = 0;
    tx(0, 0, 6'd5, 0, 0, 0, 5, 64'h1234BEAA, "rd5_after_rdwr");
    tx(0, 1, 6'd7, 64'hFFFFFFFF, 8'hF, 0, 5, 64'h1234BEAA, "wr7");
    tx(0, 0, 6'd7, 0, 0, 0, 5, 64'hFFFFFFFF, "rd7");
    @(negedge clk);
    wr0 = 1; ad0 = 6'd7; wd0 = 0; be0 = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midaccess_busy", 64'(bw0), 64'd1);
    rst = 1;
    #1;
    chk("rst_busy_drop", 64'(bw0), 64'd0);
    chk("rst_rdata_clear", {32'b0, rdat0}, 64'd0);
    wr0 = 0;
    #1;
    rst = 0;
    tx(0, 0, 6'd7, 0, 0, 0, 5, 64'h0, "rd7_after_rst");
    tx(0, 0, 6'd5, 0, 0, 0, 5, 64'h0, "rd5_after_rst");
    tx(1, 1, 6'd3, 64'h0123456789ABCDEF, 8'hFF, 0, 2, 64'h0, "w64_full");
    tx(1, 0, 6'd3, 0, 0, 0, 2, 64'h0123456789ABCDEF, "r64_full");
    tx(1, 1, 6'd3, 64'hFFFFFFFFFFFFFFFF, 8'hA5, 0, 2, 64'h0123456789ABCDEF, "w64_lanes");
    tx(1, 0, 6'd3, 0, 0, 0, 2, 64'hFF23FF6789FFCDFF, "r64_merge");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
